// File: rtl/lights_phase_timer.sv
// Phase pacing timer for the traffic-lights sequencer: holds each RAG phase, then pulses step.
// Optional pedestrian handling is built when LIGHTS_PED_EN is defined.
module lights_phase_timer #(
    parameter int CNT_W       = 8,
    parameter int T_RED       = 20,
    parameter int T_RED_AMBER = 4,
    parameter int T_GREEN     = 20,
    parameter int T_AMBER     = 4,
    parameter int T_PED       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       rag,
    input  logic             ped_req,
    output logic             step,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_pending,
    output logic             ped_walk,
    output logic             fault
);

    // state    | meaning
    // LOAD     | sample rag, load phase duration (duration 1 or illegal code goes straight to STEP)
    // COUNT    | remaining counts down; leaves when the next value would be 0
    // STEP     | step pulse is high, remaining is 0
    // WAIT_ACK | wait up to 4 cycles for rag to move away from the captured phase
    typedef enum logic [1:0] {LOAD, COUNT, STEP, WAIT_ACK} state_t;

    localparam logic [2:0] RAG_RED       = 3'b100;
    localparam logic [2:0] RAG_RED_AMBER = 3'b110;
    localparam logic [2:0] RAG_GREEN     = 3'b001;
    localparam logic [2:0] RAG_AMBER     = 3'b010;

    localparam logic [CNT_W-1:0] D_RED       = CNT_W'(T_RED);
    localparam logic [CNT_W-1:0] D_RED_PED   = CNT_W'(T_RED + T_PED);
    localparam logic [CNT_W-1:0] D_RED_AMBER = CNT_W'(T_RED_AMBER);
    localparam logic [CNT_W-1:0] D_GREEN     = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] D_AMBER     = CNT_W'(T_AMBER);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state;
    logic [2:0]       phase_q;
    logic [1:0]       wait_cnt;
    logic             legal;
    logic             serve;
    logic             load_en;
    logic [CNT_W-1:0] dur;

    assign load_en = enable && (state == LOAD);

`ifdef LIGHTS_PED_EN
    assign serve = (rag == RAG_RED) && ped_pending;

    // A serving LOAD clears the latch even if ped_req is still high; it re-sets next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
        end else begin
            if (load_en && serve)
                ped_pending <= 1'b0;
            else if (ped_req)
                ped_pending <= 1'b1;

            if (load_en)
                ped_walk <= serve;
            else if (enable && (state == STEP))
                ped_walk <= 1'b0;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign serve          = 1'b0;
    assign ped_pending    = 1'b0;
    assign ped_walk       = 1'b0;
`endif

    always_comb begin
        legal = 1'b1;
        dur   = '0;
        case (rag)
            RAG_RED:       dur = serve ? D_RED_PED : D_RED;
            RAG_RED_AMBER: dur = D_RED_AMBER;
            RAG_GREEN:     dur = D_GREEN;
            RAG_AMBER:     dur = D_AMBER;
            default:       legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            phase_q   <= 3'b000;
            wait_cnt  <= 2'd0;
            remaining <= '0;
            step      <= 1'b0;
            fault     <= 1'b0;
        end else if (!enable) begin
            step <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    phase_q  <= rag;
                    wait_cnt <= 2'd0;
                    if (!legal || (dur <= ONE)) begin
                        fault     <= fault | !legal;
                        remaining <= '0;
                        step      <= 1'b1;
                        state     <= STEP;
                    end else begin
                        remaining <= dur - ONE;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        step  <= 1'b1;
                        state <= STEP;
                    end
                end
                STEP: begin
                    step  <= 1'b0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (rag != phase_q) begin
                        state <= LOAD;
                    end else if (wait_cnt == 2'd3) begin
                        fault <= 1'b1;
                        state <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
